riscuinho_ng_mem_arbiter: RTL and testbench

//  Shares the single-port unified memory (mem_inst) between NUM_REQ requesters:
//  0 = debug/loader port, 1 = load/store unit, 2 = instruction fetch.

---
 rtl/riscuinho_ng_pkg.sv | 10 +
 rtl/riscuinho_ng_rr_picker.sv | 32 +++
 rtl/riscuinho_ng_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_riscuinho_ng_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscuinho_ng_pkg.sv
// Shared types and requester indices for the riscuinho_ng memory subsystem.
package riscuinho_ng_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam int REQ_DBG    = 0;
  localparam int REQ_LSU    = 1;
  localparam int REQ_IFETCH = 2;

endpackage

// File: rtl/riscuinho_ng_rr_picker.sv
// Combinational one-hot picker: scans req starting at base and wraps around,
// returning the first set bit as a one-hot grant and as an index.
module riscuinho_ng_rr_picker #(
  parameter int N    = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] base,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] id
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    id    = '0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(base) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/riscuinho_ng_mem_arbiter.sv
// Single-outstanding arbiter in front of the unified memory. Define MEM_ARB_RR_EN
// for round-robin arbitration; otherwise the lowest requester index wins.
module riscuinho_ng_mem_arbiter
  import riscuinho_ng_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*32-1:0]        req_wdata,
  input  logic [NUM_REQ*4-1:0]         req_wstrb,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic                         resp_err,
  output logic [31:0]                  resp_rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [3:0]                   mem_wstrb,
  input  logic [31:0]                  mem_rdata,
  output arb_state_t                   dbg_state
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int MA_W = $clog2(MEM_WORDS);
  localparam int WI_W = ADDR_W - 2;
  localparam logic [2:0] WAIT_INIT = 3'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  // Handshake: a requester's transaction is taken on the rising edge where
  // req_valid[i] & req_ready[i]; req_ready is only offered in IDLE or RESP.
  arb_state_t          state;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     pick_base;
  logic [ID_W-1:0]     cmd_id;
  logic                cmd_we;
  logic                cmd_oor;
  logic                accept;
  logic [2:0]          wait_cnt;
  logic [WI_W-1:0]     sel_widx;
  logic                sel_oor;

  riscuinho_ng_rr_picker #(.N(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req  (req_valid),
    .base (pick_base),
    .gnt  (pick_gnt),
    .id   (pick_id)
  );

`ifdef MEM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  assign pick_base = rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + ID_W'(1);
    end
  end
`else
  assign pick_base = '0;
`endif

  assign req_ready  = (state == IDLE || state == RESP) ? pick_gnt : '0;
  assign accept     = |req_ready;
  assign sel_widx   = req_addr[int'(pick_id)*ADDR_W + 2 +: WI_W];
  assign sel_oor    = sel_widx >= WI_W'(MEM_WORDS);
  // Memory data arrives during RESP itself, so read data is passed straight through.
  assign resp_rdata = (state == RESP && !cmd_we && !cmd_oor) ? mem_rdata : '0;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_id     <= '0;
      cmd_we     <= 1'b0;
      cmd_oor    <= 1'b0;
      wait_cnt   <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            state     <= ISSUE;
            cmd_id    <= pick_id;
            cmd_we    <= req_we[pick_id];
            cmd_oor   <= sel_oor;
            mem_en    <= !sel_oor;
            mem_we    <= req_we[pick_id] && !sel_oor;
            mem_addr  <= sel_widx[MA_W-1:0];
            mem_wdata <= req_wdata[int'(pick_id)*32 +: 32];
            mem_wstrb <= req_wstrb[int'(pick_id)*4 +: 4];
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (cmd_oor || MEM_LATENCY == 1) begin
            state              <= RESP;
            resp_valid[cmd_id] <= 1'b1;
            resp_err           <= cmd_oor;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state              <= RESP;
            resp_valid[cmd_id] <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscuinho_ng_mem_arbiter.sv
// Bench for riscuinho_ng_mem_arbiter: one instance with MEM_LATENCY=1, one with
// MEM_LATENCY=3, each behind a behavioural memory, checked by a scoreboard.
module tb_riscuinho_ng_mem_arbiter;
  import riscuinho_ng_pkg::*;

  typedef struct {
    int          id;
    bit          we;
    bit          err;
    logic [9:0]  widx;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] data;
    int          acc;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  req_valid [2];
  logic [2:0]  req_ready [2];
  logic [2:0]  req_we    [2];
  logic [95:0] req_addr  [2];
  logic [95:0] req_wdata [2];
  logic [11:0] req_wstrb [2];
  logic [2:0]  resp_valid[2];
  logic        resp_err  [2];
  logic [31:0] resp_rdata[2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [9:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic [31:0] mem_rdata [2];
  arb_state_t  dbg_state [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscuinho_ng_mem_arbiter #(
      .NUM_REQ(3), .ADDR_W(32), .MEM_WORDS(1024), .MEM_LATENCY(g == 0 ? 1 : 3)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wstrb  (req_wstrb[g]),
      .resp_valid (resp_valid[g]),
      .resp_err   (resp_err[g]),
      .resp_rdata (resp_rdata[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_wstrb  (mem_wstrb[g]),
      .mem_rdata  (mem_rdata[g]),
      .dbg_state  (dbg_state[g])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // behavioural memory: read data valid lat(k) cycles after the mem_en cycle
  logic [31:0] mem  [2][1024];
  logic [31:0] pipe [2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
      if (mem_en[k]) begin
        if (mem_we[k]) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[k][b]) mem[k][mem_addr[k]][b*8 +: 8] <= mem_wdata[k][b*8 +: 8];
        end
        pipe[k][0] <= mem[k][mem_addr[k]];
      end
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // scoreboard state
  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q   [2][$];
  int          exp_gnt [2][$];
  logic [31:0] ref_mem [2][1024];
  bit          en_seen [2];
  bit          stream_chk[2];
  int          stream_n  [2];
  int          prev_acc  [2];

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] outs(input int k);
    return {9'd0, req_ready[k], resp_valid[k], resp_err[k], resp_rdata[k], mem_en[k],
            mem_we[k], mem_addr[k], mem_wdata[k], mem_wstrb[k]};
  endfunction

  always @(negedge clk) begin : mon_blk
    exp_t        e;
    logic [2:0]  acc;
    int          id;
    logic [29:0] widx;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        if (resp_valid[k] != '0) check("resp_in_rst", resp_valid[k], 0);
        exp_q[k].delete();
        en_seen[k] = 1'b0;
      end else begin
        if (resp_valid[k] != '0) begin
          if (exp_q[k].size() == 0) begin
            check("resp_unexp", resp_valid[k], 0);
          end else begin
            e = exp_q[k].pop_front();
            check("resp_id", resp_valid[k], 96'(3'b001 << e.id));
            check("resp_err", resp_err[k], e.err);
            check("resp_rdata", resp_rdata[k], e.data);
            check("resp_lat", cyc - e.acc, e.err ? 2 : lat(k) + 1);
            check("mem_en_seen", en_seen[k], !e.err);
          end
        end else if (exp_q[k].size() != 0) begin
          check("ready_busy", req_ready[k], 0);
        end
        if (mem_en[k]) begin
          if (exp_q[k].size() == 0) begin
            check("mem_en_unexp", mem_en[k], 0);
          end else begin
            e = exp_q[k][0];
            check("mem_en_cyc", cyc - e.acc, 1);
            check("mem_addr", mem_addr[k], e.widx);
            check("mem_we", mem_we[k], e.we);
            if (e.we) check("mem_wr", {mem_wstrb[k], mem_wdata[k]}, {e.wstrb, e.wdata});
            en_seen[k] = 1'b1;
          end
        end
        acc = req_valid[k] & req_ready[k];
        if (req_ready[k] != '0) check("ready_onehot", $countones(req_ready[k]), 1);
        if (acc != '0) begin
          id = 0;
          for (int i = 0; i < 3; i++) if (acc[i]) id = i;
          if (exp_gnt[k].size() != 0) check("grant_id", id, exp_gnt[k].pop_front());
          if (stream_chk[k]) begin
            if (stream_n[k] > 0) check("acc_gap", cyc - prev_acc[k], lat(k) + 1);
            stream_n[k]++;
            prev_acc[k] = cyc;
          end
          widx    = req_addr[k][id*32 + 2 +: 30];
          e.id    = id;
          e.we    = req_we[k][id];
          e.err   = (widx >= 30'd1024);
          e.widx  = widx[9:0];
          e.wdata = req_wdata[k][id*32 +: 32];
          e.wstrb = req_wstrb[k][id*4 +: 4];
          e.acc   = cyc;
          e.data  = (e.we || e.err) ? 32'd0 : ref_mem[k][widx[9:0]];
          if (e.we && !e.err)
            for (int b = 0; b < 4; b++)
              if (e.wstrb[b]) ref_mem[k][widx[9:0]][b*8 +: 8] = e.wdata[b*8 +: 8];
          en_seen[k] = 1'b0;
          exp_q[k].push_back(e);
        end
      end
    end
  end

  // driver tasks
  task automatic do_req(input int k, input int id, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st);
    int n = 0;
    req_we[k][id]           = we;
    req_addr[k][id*32 +: 32]  = addr;
    req_wdata[k][id*32 +: 32] = wd;
    req_wstrb[k][id*4 +: 4]   = st;
    req_valid[k][id]        = 1'b1;
    while (1) begin
      @(negedge clk);
      if (req_ready[k][id]) break;
      n++;
      if (n > 50) begin
        check("req_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[k][id] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (exp_q[k].size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q[k].size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic contend(input int k);
    int cnt = 0;
    int n   = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_gnt[k].push_back(i % 3);
`else
      exp_gnt[k].push_back(0);
`endif
    end
    req_we[k]    = 3'b000;
    req_addr[k]  = {32'h8, 32'h100, 32'h8};
    req_valid[k] = 3'b111;
    while (cnt < 6 && n < 100) begin
      @(negedge clk);
      if (req_ready[k] != '0) cnt++;
      n++;
    end
    @(posedge clk); #1;
    req_valid[k] = 3'b000;
    check("contend_cnt", cnt, 6);
    drain(k);
    check("contend_gnt_left", exp_gnt[k].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    int w;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0; req_we[k] = '0; req_addr[k] = '0;
      req_wdata[k] = '0; req_wstrb[k] = '0;
      stream_chk[k] = 1'b0; stream_n[k] = 0; prev_acc[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_outs", outs(k), 0);
      check("rst_state", dbg_state[k], IDLE);
    end
    rst_n = 1'b1;

    for (int k = 0; k < 2; k++) begin
      // single read of a word loaded through the debug port
      do_req(k, REQ_DBG, 1'b1, 32'h100, 32'h03cfa639, 4'hf);
      do_req(k, REQ_LSU, 1'b0, 32'h100, 32'h0, 4'h0);
      drain(k);
      // byte-masked write
      do_req(k, REQ_DBG, 1'b1, 32'h8, 32'hAABBCCDD, 4'hf);
      do_req(k, REQ_DBG, 1'b1, 32'h8, 32'h1D207A00, 4'b0011);
      drain(k);
      check("wstrb_mem", mem[k][2], 32'hAABB7A00);
      // out-of-range address
      do_req(k, REQ_IFETCH, 1'b0, 32'h1000, 32'h0, 4'h0);
      drain(k);
      // back-to-back reads from one requester
      stream_n[k]   = 0;
      stream_chk[k] = 1'b1;
      for (int i = 0; i < 4; i++)
        do_req(k, REQ_LSU, 1'b0, (i % 2 == 0) ? 32'h100 : 32'h8, 32'h0, 4'h0);
      drain(k);
      stream_chk[k] = 1'b0;
      check("stream_n", stream_n[k], 4);
      // random traffic over a small window
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 2);
        do_req(k, r, 1'b1, 32'h40 + 32'(i * 4), $urandom, 4'hf);
      end
      for (int i = 0; i < 12; i++) begin
        r = $urandom_range(0, 2);
        w = $urandom_range(0, 7);
        do_req(k, r, 1'($urandom_range(0, 1)), 32'h40 + 32'(w * 4), $urandom,
               4'($urandom_range(0, 15)));
      end
      drain(k);
      // contention from a freshly reset arbiter
      rst_pulse();
      contend(k);
    end

    // reset while the latency-3 instance is waiting on memory
    do_req(1, REQ_LSU, 1'b0, 32'h100, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("mid_wait_state", dbg_state[1], WAIT);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", outs(1), 0);
    check("mid_rst_state", dbg_state[1], IDLE);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req(1, REQ_LSU, 1'b0, 32'h100, 32'h0, 4'h0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
